multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named as below.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- Op  in  2  instruction class (00 data, 01 memory, 10 branch, 11 undefined)
- Funct  in  6  Funct[5] = I, Funct[4:1] = cmd, Funct[0] = S (data) or L (memory)
- Rd  in  4  destination register
- IRWrite  out  1  instruction register load
- NextPC  out  1  PC update enable
- AdrSrc  out  1  memory address source (0 PC, 1 Result)
- ALUSrcA  out  1  ALU A source (0 Rn, 1 PC)
- ALUSrcB  out  2  ALU B source (00 RD2, 01 ExtImm, 10 const 4)
- ResultSrc  out  2  result mux (00 ALUOut, 01 Data, 10 ALUResult)
- ALUControl  out  2  ALU operation (00 add, 01 sub, 10 and, 11 orr)
- FlagW  out  2  flag-write request to condition logic
- PCS  out  1  PC-write request to condition logic
- RegW  out  1  register-write request to condition logic
- MemW  out  1  memory-write request to condition logic

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH.
REQ-004 FETCH SHALL always go to DECODE.
REQ-005 DECODE SHALL go to: MEMADR if Op=01; EXECUTER if Op=00 and Funct[5]=0; EXECUTEI if Op=00 and Funct[5]=1; BRANCH if Op=10; FETCH if Op=11 (treated as a NOP).
REQ-006 MEMADR SHALL go to MEMREAD if Funct[0]=1, else to MEMWRITE.
REQ-007 The remaining transitions SHALL be: MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
REQ-008 Latency in cycles, counted from FETCH through the final state inclusive, SHALL be: LDR 5, STR 4, data-processing 4, branch 3, undefined 2.
REQ-009 Outputs asserted per state SHALL be as follows; any output not listed is 0:
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
- MEMADR: ALUSrcA=0, ALUSrcB=01
- MEMREAD: AdrSrc=1, ResultSrc=00
- MEMWB: ResultSrc=01, RegW=1
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1
- EXECUTER: ALUSrcB=00, ALUOp=1
- EXECUTEI: ALUSrcB=01, ALUOp=1
- ALUWB: ResultSrc=00, RegW=1
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1
REQ-010 Internal ALUOp=0 SHALL give ALUControl=00 and FlagW=00.
REQ-011 With ALUOp=1, cmd SHALL decode as: 0100->00, 0010->01, 0000->10, 1100->11; any other cmd gives ALUControl=00 and FlagW=00.
REQ-012 With ALUOp=1 and a valid cmd, FlagW[1] SHALL equal Funct[0], and FlagW[0] SHALL equal Funct[0] AND (cmd is add or sub).
REQ-013 PCS SHALL equal Branch OR (RegW AND Rd=4'b1111), evaluated combinationally in the current state.
REQ-014 Funct, Op and Rd SHALL be sampled only on the DECODE->next and MEMADR->next edges; they are held stable by the instruction register.

Reset
REQ-015 Asserting reset low SHALL force the state to FETCH immediately and asynchronously, including mid-instruction.
REQ-016 While reset is low, IRWrite, NextPC, RegW, MemW, PCS and FlagW SHALL be 0; all other outputs take their FETCH values.
REQ-017 On the first rising clk edge after reset deasserts, the FSM SHALL be in FETCH with IRWrite=1 and NextPC=1.

Structure
REQ-018 A shared package SHALL hold the state enum, the ALUSrcB, ResultSrc and ALUControl encodings, and the cmd constants.
REQ-019 The ALU decode (REQ-010 to REQ-012) SHALL be a sub-module named alu_decoder.
REQ-020 State SHALL be held in a single registered enum; next-state and output logic SHALL be combinational.

Verification
REQ-021 Reset low for 3 cycles, then released -> state FETCH, IRWrite=1, NextPC=1 on the first cycle.
REQ-022 Op=01, Funct=6'b000001, Rd=0011 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegW=1 only in MEMWB; PCS=0.
REQ-023 Op=01, Funct=6'b000000 -> MEMWRITE follows MEMADR with MemW=1 for exactly 1 cycle; back in FETCH at cycle 4.
REQ-024 Op=00, Funct=6'b100101 (I=1, sub, S=1), Rd=1111 -> EXECUTEI with ALUControl=01 and FlagW=11; ALUWB with RegW=1 and PCS=1.
REQ-025 Op=10 -> BRANCH with PCS=1 and ALUSrcB=01 for 1 cycle; Op=11 -> returns to FETCH straight after DECODE.
REQ-026 Reset asserted low during MEMREAD -> state is FETCH within the same cycle and MemW/RegW stay 0 until re-fetch.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// State enum, mux select codes, ALU control codes and cmd constants.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_UND  = 2'b11;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU operation and flag-write decode from the instruction cmd field.
// Unknown cmds fall back to add with no flag update.
module alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_ctrl,
  output logic [1:0] o_flag_w
);

  logic [3:0] w_cmd;
  logic       w_s;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_flag_w   = 2'b00;
    if (i_alu_op) begin
      case (w_cmd)
        CMD_ADD: begin
          o_alu_ctrl = ALU_ADD;
          o_flag_w   = {w_s, w_s};
        end
        CMD_SUB: begin
          o_alu_ctrl = ALU_SUB;
          o_flag_w   = {w_s, w_s};
        end
        CMD_AND: begin
          o_alu_ctrl = ALU_AND;
          o_flag_w   = {w_s, 1'b0};
        end
        CMD_ORR: begin
          o_alu_ctrl = ALU_ORR;
          o_flag_w   = {w_s, 1'b0};
        end
        default: begin
          o_alu_ctrl = ALU_ADD;
          o_flag_w   = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle ARM-style datapath.
// Write-type outputs are gated off while reset is held low.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW
);

  state_t     r_state;
  state_t     w_next;
  logic       w_irw;
  logic       w_npc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_alu_op;
  logic [1:0] w_flag_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DATA: w_next = Funct[5] ? S_EXECUTEI
                                     : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          OP_UND:  w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD
                                    : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_irw     = 1'b0;
    w_npc     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_alu_op  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_irw     = 1'b1;
        w_npc     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR:  ALUSrcB = SRCB_IMM;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_regw    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB  = SRCB_IMM;
        w_alu_op = 1'b1;
      end
      S_ALUWB: w_regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .i_alu_op   (w_alu_op),
    .i_funct    (Funct),
    .o_alu_ctrl (ALUControl),
    .o_flag_w   (w_flag_w)
  );

  assign IRWrite = reset & w_irw;
  assign NextPC  = reset & w_npc;
  assign RegW    = reset & w_regw;
  assign MemW    = reset & w_memw;
  assign FlagW   = reset ? w_flag_w : 2'b00;
  assign PCS     = reset & (w_branch |
                   (w_regw & (Rd == 4'b1111)));

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM.
// Output bundle checked per cycle against hand-built vectors.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       NextPC;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;

  int n_chk;
  int n_fail;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW)
  );

  // {IRW,NPC,Adr,A,B[2],Res[2],ALU[2],FlagW[2],PCS,RegW,MemW}
  logic [15:0] vec;
  assign vec = {IRWrite, NextPC, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl,
                FlagW, PCS, RegW, MemW};

  localparam logic [15:0] V_RST    = 16'b0001_1010_0000_000;
  localparam logic [15:0] V_FETCH  = 16'b1101_1010_0000_000;
  localparam logic [15:0] V_DECODE = 16'b0001_1010_0000_000;
  localparam logic [15:0] V_MEMADR = 16'b0000_0100_0000_000;
  localparam logic [15:0] V_MEMRD  = 16'b0010_0000_0000_000;
  localparam logic [15:0] V_MEMWB  = 16'b0000_0001_0000_010;
  localparam logic [15:0] V_MEMWR  = 16'b0010_0000_0000_001;
  localparam logic [15:0] V_EXI_SB = 16'b0000_0100_0111_000;
  localparam logic [15:0] V_WB_PC  = 16'b0000_0000_0000_110;
  localparam logic [15:0] V_WB     = 16'b0000_0000_0000_010;
  localparam logic [15:0] V_EXR_OR = 16'b0000_0000_1110_000;
  localparam logic [15:0] V_EXR_AN = 16'b0000_0000_1000_000;
  localparam logic [15:0] V_EXI_XX = 16'b0000_0100_0000_000;
  localparam logic [15:0] V_BRANCH = 16'b0000_0110_0000_100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Op = 2'b11; Funct = 6'b0; Rd = 4'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (vec !== V_RST) begin
        n_fail++;
        $display("FAIL reset_hold[%0d] got %b want %b",
                 i, vec, V_RST);
      end
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (vec !== V_FETCH) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b",
               vec, V_FETCH);
    end
  endtask

  task automatic test_ldr();
    logic [15:0] e [5];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    Op = 2'b01; Funct = 6'b000001; Rd = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_chk++;
      if (vec !== e[i]) begin
        n_fail++;
        $display("FAIL ldr[%0d] got %b want %b",
                 i, vec, e[i]);
      end
    end
    step();
  endtask

  task automatic test_str();
    logic [15:0] e [5];
    e = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
    Op = 2'b01; Funct = 6'b000000; Rd = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_chk++;
      if (vec !== e[i]) begin
        n_fail++;
        $display("FAIL str[%0d] got %b want %b",
                 i, vec, e[i]);
      end
    end
  endtask

  task automatic test_dp_imm();
    logic [15:0] e [4];
    e = '{V_FETCH, V_DECODE, V_EXI_SB, V_WB_PC};
    Op = 2'b00; Funct = 6'b100101; Rd = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      n_chk++;
      if (vec !== e[i]) begin
        n_fail++;
        $display("FAIL dp_imm[%0d] got %b want %b",
                 i, vec, e[i]);
      end
    end
    step();
  endtask

  task automatic test_dp_reg();
    logic [15:0] e [4];
    logic [5:0]  f [3];
    logic [15:0] x [3];
    f = '{6'b011001, 6'b000000, 6'b100011};
    x = '{V_EXR_OR, V_EXR_AN, V_EXI_XX};
    Op = 2'b00; Rd = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      Funct = f[k];
      e = '{V_FETCH, V_DECODE, x[k], V_WB};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        n_chk++;
        if (vec !== e[i]) begin
          n_fail++;
          $display("FAIL dp_reg%0d[%0d] got %b want %b",
                   k, i, vec, e[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_branch_undef();
    logic [15:0] e [6];
    e = '{V_FETCH, V_DECODE, V_BRANCH,
          V_FETCH, V_DECODE, V_FETCH};
    Op = 2'b10; Funct = 6'b000000; Rd = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      if (i == 3) Op = 2'b11;
      n_chk++;
      if (vec !== e[i]) begin
        n_fail++;
        $display("FAIL br_und[%0d] got %b want %b",
                 i, vec, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    Op = 2'b01; Funct = 6'b000001; Rd = 4'b1111;
    step();
    step();
    step();
    n_chk++;
    if (vec !== V_MEMRD) begin
      n_fail++;
      $display("FAIL mid_memread got %b want %b",
               vec, V_MEMRD);
    end
    #2;
    reset = 1'b0;
    #1;
    n_chk++;
    if (vec !== V_RST) begin
      n_fail++;
      $display("FAIL mid_async got %b want %b",
               vec, V_RST);
    end
    step();
    n_chk++;
    if (vec !== V_RST) begin
      n_fail++;
      $display("FAIL mid_hold got %b want %b",
               vec, V_RST);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (vec !== V_FETCH) begin
      n_fail++;
      $display("FAIL mid_refetch got %b want %b",
               vec, V_FETCH);
    end
    step();
    n_chk++;
    if (vec !== V_DECODE) begin
      n_fail++;
      $display("FAIL mid_decode got %b want %b",
               vec, V_DECODE);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_ldr();
    test_str();
    test_dp_imm();
    test_dp_reg();
    test_branch_undef();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
